// File: rtl/switch_arb_pkg.sv
// Shared types for the crossbar arbiter: port masks, port indices and per-input FSM states.
package switch_arb_pkg;

    localparam int NUM_PORTS_DEF = 4;

    typedef logic [3:0] port_mask_t;
    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_ACTIVE
    } arb_state_e;

endpackage

// File: rtl/switch_arb_wdog.sv
// Grant-hold watchdog for one input: expire is combinational, high on the edge where the hold
// reaches WDOG_CYCLES cycles without req_last; WDOG_CYCLES==0 disables it.
module switch_arb_wdog #(
    parameter int WDOG_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic last,
    output logic expire
);

    localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        expire = (WDOG_CYCLES != 0) && active && !last && (cnt_q == CW'(WDOG_CYCLES - 1));
        cnt_d  = (active && !last && !expire) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/switch_xbar_arbiter.sv
// Crossbar scheduler: all-or-nothing round-robin grants of target outputs, held until req_last or watchdog.
// Define SWITCH_XBAR_ARBITER_RESERVE_EN to let a blocked input at rr_ptr reserve its outputs.
module switch_xbar_arbiter
    import switch_arb_pkg::*;
#(
    parameter int NUM_PORTS   = NUM_PORTS_DEF,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_valid,
    input  logic [NUM_PORTS*4-1:0] req_target,
    input  logic [NUM_PORTS-1:0]   req_last,
    input  logic [NUM_PORTS-1:0]   suspend_op,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [NUM_PORTS-1:0]   req_reject,
    output logic [NUM_PORTS-1:0]   out_busy,
    output logic [NUM_PORTS*2-1:0] out_sel,
    output logic [NUM_PORTS-1:0]   err_timeout
);

    localparam int IW = $bits(port_idx_t);

    arb_state_e           state_q [NUM_PORTS];
    arb_state_e           state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] eff     [NUM_PORTS];
    logic [IW-1:0]        sel_q   [NUM_PORTS];
    logic [IW-1:0]        sel_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0] busy_q, busy_d, rej_q, rej_d, tmo_q, tmo_d;
    logic [NUM_PORTS-1:0] expire, release_v, pend, cand, new_gnt, claimed;
    logic [IW-1:0]        rr_q, rr_d, idx;
    logic                 found;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign eff[i] = req_target[4*i +: NUM_PORTS] & ~(NUM_PORTS'(1) << i);
        assign out_sel[IW*i +: IW] = sel_q[i];

        switch_arb_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
            .clk    (clk),
            .reset  (reset),
            .active (state_q[i] == ARB_ACTIVE),
            .last   (req_last[i]),
            .expire (expire[i])
        );
    end

    // Scheduling sees pre-edge busy, so outputs freed this edge stay idle for one cycle.
    always_comb begin
        release_v = '0;
        pend      = '0;
        cand      = '0;
        rej_d     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            release_v[i] = (state_q[i] == ARB_ACTIVE) && (req_last[i] || expire[i]);
            pend[i]      = req_valid[i] && !rej_q[i] && (state_q[i] != ARB_ACTIVE);
            cand[i]      = pend[i] && (eff[i] != '0);
            rej_d[i]     = pend[i] && (eff[i] == '0);
        end
        tmo_d = expire;

        new_gnt = '0;
        claimed = '0;
        rr_d    = rr_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = IW'((int'(rr_q) + k) % NUM_PORTS);
            if (cand[idx] && ((eff[idx] & (busy_q | suspend_op | claimed)) == '0)) begin
                new_gnt[idx] = 1'b1;
                claimed      = claimed | eff[idx];
                if (!found) begin
                    rr_d  = IW'((int'(idx) + 1) % NUM_PORTS);
                    found = 1'b1;
                end
            end
`ifdef SWITCH_XBAR_ARBITER_RESERVE_EN
            else if (cand[idx] && (k == 0)) begin
                claimed = claimed | eff[idx];
                found   = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ARB_IDLE, ARB_WAIT: begin
                    if (new_gnt[i])   state_d[i] = ARB_ACTIVE;
                    else if (cand[i]) state_d[i] = ARB_WAIT;
                    else              state_d[i] = ARB_IDLE;
                end
                ARB_ACTIVE: begin
                    if (release_v[i]) state_d[i] = req_valid[i] ? ARB_WAIT : ARB_IDLE;
                end
                default: state_d[i] = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_PORTS; j++) begin
            sel_d[j] = sel_q[j];
            if (busy_q[j] && release_v[sel_q[j]]) begin
                busy_d[j] = 1'b0;
                sel_d[j]  = '0;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (new_gnt[i] && eff[i][j]) begin
                    busy_d[j] = 1'b1;
                    sel_d[j]  = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ARB_IDLE;
                sel_q[i]   <= '0;
            end
            busy_q <= '0;
            rej_q  <= '0;
            tmo_q  <= '0;
            rr_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
                sel_q[i]   <= sel_d[i];
            end
            busy_q <= busy_d;
            rej_q  <= rej_d;
            tmo_q  <= tmo_d;
            rr_q   <= rr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant[i] = (state_q[i] == ARB_ACTIVE);
        end
        out_busy    = busy_q;
        req_reject  = rej_q;
        err_timeout = tmo_q;
    end

endmodule

// File: doc/switch_xbar_arbiter.md
Name: switch_xbar_arbiter

Overview:
- Crossbar scheduler for the 4-port packet switch.
- Each input port requests a set of output ports using the packet target mask (single, multicast or broadcast). The arbiter grants an input only when all of its target outputs are free and not suspended (all-or-nothing), then holds the path until the packet ends.
- Drives the crossbar select lines and output busy flags.
- Sits between the input port FSMs and the output port drivers.

Parameters:
- NUM_PORTS, 4: number of switch ports; RTL generic, verified at 4.
- WDOG_CYCLES, 64: maximum cycles a grant may be held without req_last; 0 disables the watchdog.

Ports:
- clk  in  1  switch clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_PORTS  input i has a packet waiting; held until grant[i] or req_reject[i].
- req_target  in  NUM_PORTS*4  target mask of input i in bits [4i+3:4i]; stable while req_valid[i].
- req_last  in  NUM_PORTS  input i's final data cycle; meaningful only while grant[i].
- suspend_op  in  NUM_PORTS  output j is suspended; blocks new grants to j only.
- grant  out  NUM_PORTS  input i owns its target outputs; level signal.
- req_reject  out  NUM_PORTS  one-cycle pulse: request i illegal, dropped.
- out_busy  out  NUM_PORTS  output j currently owned.
- out_sel  out  NUM_PORTS*2  owning input index for output j; 0 when not busy.
- err_timeout  out  NUM_PORTS  one-cycle pulse: watchdog forced release of input i.

Behaviour:
- Reset (reset==0 at clk edge): grant, req_reject, out_busy, out_sel and err_timeout all 0; rr_ptr=0; watchdogs cleared.
- Reset mid-packet: all paths are dropped immediately, with no err_timeout pulse.
- Effective target: eff[i] = req_target[i] & ~(1<<i). This masks the own bit, so broadcast 4'hf from port 1 targets 4'hd.
- Illegal request: eff[i]==0. req_reject[i] pulses the cycle after req_valid[i] is sampled, and grant[i] stays 0.
- Per-input FSM:
  - IDLE -> WAIT on req_valid.
  - WAIT -> ACTIVE on grant.
  - WAIT -> IDLE on reject.
  - ACTIVE -> IDLE on req_last or watchdog expiry.
- Scheduling (each edge):
  - Scan inputs in order rr_ptr, rr_ptr+1, ... mod NUM_PORTS.
  - Input i in WAIT is granted if (eff[i] & (busy_now | suspend_op | claimed))==0. claimed accumulates the outputs granted earlier in the same scan.
  - Disjoint requests may be granted in the same cycle.
- Grant latency: one cycle from the first sampled req_valid, when outputs are free.
- Grant update: grant[i], out_busy, and out_sel for every output in eff[i] update together.
- rr_ptr: after any grant, rr_ptr <= (highest-priority granted index in scan order) + 1 mod NUM_PORTS. Otherwise unchanged.
- Release:
  - req_last[i] sampled with grant[i] clears grant[i], out_busy and out_sel for i's outputs at that edge.
  - Scheduling at that edge uses pre-edge busy, so freed outputs can be re-granted one edge later. This gives exactly one idle cycle.
- Simultaneous req_last[i] and new req_valid[i]: the new request enters WAIT and is not granted on that edge.
- Suspend: suspend_op affects only new grants. Active paths continue through suspend.
- Watchdog:
  - A counter runs while grant[i].
  - When the count reaches WDOG_CYCLES without req_last, grant is forcibly released (same timing as req_last) and err_timeout[i] pulses.
  - The counter clears on release.
- Invariant: no output is owned by more than one input at any time.

Optional Feature:
- Macro: SWITCH_XBAR_ARBITER_RESERVE_EN.
- Defined:
  - If the input at rr_ptr is in WAIT and blocked, its eff outputs are reserved. No other input may be granted any of them, even if they are free.
  - This prevents multicast/broadcast starvation.
  - rr_ptr does not advance past a blocked reserving input.
- Undefined: pure greedy scan; a blocked input does not reserve anything.

Decomposition:
- Package switch_arb_pkg:
  - NUM_PORTS_DEF=4.
  - typedef port_mask_t (logic[3:0]).
  - typedef port_idx_t (logic[1:0]).
  - enum arb_state_e {ARB_IDLE, ARB_WAIT, ARB_ACTIVE}.
- Sub-module switch_arb_wdog: per-input grant-hold counter with expire pulse. Instantiated NUM_PORTS times.

Test Plan:
- Reset, then req_valid=4'b0001 with target0=4'h2 -> grant[0]=1 one cycle later; out_busy=4'h2; out_sel[3:2]=0. req_last after 5 cycles -> grant[0] low next edge, out_busy=0.
- Inputs 0 and 2 both request target 4'h2 from rr_ptr=0 -> input 0 granted first; input 2 granted exactly one idle cycle after input 0's release.
- Input 1 target 4'h8 and input 3 target 4'h1 in the same cycle -> both granted in the same cycle; out_busy=4'h9.
- Input 2 broadcast 4'hf while output 0 is busy -> no grant until output 0 frees; then eff=4'hb granted all-or-nothing. With RESERVE_EN and rr_ptr=2, competing singles to outputs 1 and 3 are blocked meanwhile.
- Input 0 target 4'h1 -> req_reject[0] pulses one cycle, no grant. Separately, suspend_op[3]=1 blocks a new request to output 3 while an active path to output 3 continues.
- WDOG_CYCLES=8, grant held without req_last -> err_timeout pulses and grant drops after 8 cycles. reset low mid-grant -> all outputs 0 at next edge.
